// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run controller.
// State encoding, default counter sizing and a printable state-name helper.
package run_ctrl_pkg;

    // Run sequencing states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Default cycle-counter width and drain length.
    localparam int DEF_CNT_W        = 16;
    localparam int DEF_DRAIN_CYCLES = 2;

    // Drain counter width; holds DRAIN_CYCLES-1 for DRAIN_CYCLES in 1..15.
    localparam int DRAIN_W = 4;

    // Five-character ASCII name of a state, for display purposes.
    function automatic logic [39:0] state_name(input state_e s);
        case (s)
            ST_IDLE:  state_name = "IDLE ";
            ST_ARM:   state_name = "ARM  ";
            ST_RUN:   state_name = "RUN  ";
            ST_DRAIN: state_name = "DRAIN";
            ST_DONE:  state_name = "DONE ";
            default:  state_name = "?????";
        endcase
    endfunction

endpackage

// File: rtl/run_controller_sat_counter.sv
// sat_counter: WIDTH-bit up counter with synchronous clear and a
// saturating increment (sticks at all-ones instead of wrapping).
// clr has priority over en.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_controller.sv
// run_controller: sequences one program run of the single-cycle core using
// the Start/Ack handshake. Holds the PC at StartAddr while Start is high,
// launches on Start falling, runs until Halt, drains in-flight writes for
// DRAIN_CYCLES cycles and then raises Ack. Counts RUN cycles in CycleCnt.
// Optional build macro RUN_WATCHDOG_EN adds a cycle-limit watchdog that
// forces the drain after WDOG_LIMIT run cycles and sets the sticky Timeout.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W         = 10,
    parameter int unsigned START_ADDR   = 0,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int unsigned WDOG_LIMIT   = 32'h0000_FFF0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    output logic             PcInit,
    output logic [PC_W-1:0]  StartAddr,
    output logic             PcEn,
    output logic             WrEn,
    output logic             Ack,
    output logic [CNT_W-1:0] CycleCnt,
    output logic             Timeout
);

    // Drain counter starts one below the drain length so that reaching zero
    // marks the last drain cycle.
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

`ifdef RUN_WATCHDOG_EN
    // Counter value seen on the last permitted run cycle.
    localparam logic [CNT_W-1:0] WDOG_MATCH = CNT_W'(WDOG_LIMIT - 1);
`endif

    state_e             state_q;
    state_e             state_d;
    logic [DRAIN_W-1:0] drain_q;
    logic [DRAIN_W-1:0] drain_d;
    logic               pc_init_q;
    logic               pc_init_d;
    logic               pc_en_q;
    logic               pc_en_d;
    logic               wr_en_q;
    logic               wr_en_d;
    logic               ack_q;
    logic               ack_d;
    logic [CNT_W-1:0]   cycle_cnt;
    logic               cnt_clr;
    logic               cnt_en;
`ifdef RUN_WATCHDOG_EN
    logic               wdog_fire;
    logic               timeout_q;
    logic               timeout_d;
`endif

    // Next-state, drain counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
`ifdef RUN_WATCHDOG_EN
        wdog_fire = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // Launch on the falling edge of Start.
                if (!Start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Start is ignored here; a genuine Halt beats the watchdog.
                if (Halt) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
`ifdef RUN_WATCHDOG_EN
                else if (cycle_cnt == WDOG_MATCH) begin
                    state_d   = ST_DRAIN;
                    drain_d   = DRAIN_LOAD;
                    wdog_fire = 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (Start) begin
                    state_d = ST_ARM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the decode of the next state, so
        // they always match the state register one cycle later.
        pc_init_d = (state_d == ST_ARM);
        pc_en_d   = (state_d == ST_RUN);
        wr_en_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        ack_d     = (state_d == ST_DONE);

`ifdef RUN_WATCHDOG_EN
        // Timeout is sticky through DRAIN/DONE and clears on entering ARM.
        timeout_d = timeout_q;
        if (state_d == ST_ARM) begin
            timeout_d = 1'b0;
        end else if (wdog_fire) begin
            timeout_d = 1'b1;
        end
`endif
    end

    // FSM state, drain counter and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            drain_q   <= '0;
            pc_init_q <= 1'b0;
            pc_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            ack_q     <= 1'b0;
`ifdef RUN_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            pc_init_q <= pc_init_d;
            pc_en_q   <= pc_en_d;
            wr_en_q   <= wr_en_d;
            ack_q     <= ack_d;
`ifdef RUN_WATCHDOG_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    // The count is cleared on entry to ARM so it reads zero in the first ARM
    // cycle, and advances once per RUN cycle; it freezes in DRAIN/DONE.
    assign cnt_clr = (state_d == ST_ARM);
    assign cnt_en  = (state_q == ST_RUN);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .clk   (Clk),
        .srst  (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cycle_cnt)
    );

    assign PcInit    = pc_init_q;
    assign StartAddr = PC_W'(START_ADDR);
    assign PcEn      = pc_en_q;
    assign WrEn      = wr_en_q;
    assign Ack       = ack_q;
    assign CycleCnt  = cycle_cnt;
`ifdef RUN_WATCHDOG_EN
    assign Timeout   = timeout_q;
`else
    assign Timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Testbench for run_controller. Each run is described by its Start-high
// length h and the RUN cycle n on which Halt is asserted; the expected
// enable counts, Ack cycle, CycleCnt and Timeout are computed from those
// numbers with plain arithmetic.
module tb_run_controller;

    localparam int PC_W       = 10;
    localparam int START_ADDR = 5;
    localparam int CNT_W      = 4;
    localparam int DRAIN      = 2;
    localparam int WDOG       = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic             Halt;
    logic             PcInit;
    logic [PC_W-1:0]  StartAddr;
    logic             PcEn;
    logic             WrEn;
    logic             Ack;
    logic [CNT_W-1:0] CycleCnt;
    logic             Timeout;

    int checks   = 0;
    int failures = 0;

    run_controller #(
        .PC_W         (PC_W),
        .START_ADDR   (START_ADDR),
        .CNT_W        (CNT_W),
        .DRAIN_CYCLES (DRAIN),
        .WDOG_LIMIT   (WDOG)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Halt      (Halt),
        .PcInit    (PcInit),
        .StartAddr (StartAddr),
        .PcEn      (PcEn),
        .WrEn      (WrEn),
        .Ack       (Ack),
        .CycleCnt  (CycleCnt),
        .Timeout   (Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Apply inputs, take one clock edge, then let outputs settle before sampling.
    task automatic step(input logic s, input logic h);
        Start = s;
        Halt  = h;
        @(posedge Clk);
        #1;
    endtask

    // Reference outcome of a run whose Halt arrives on RUN cycle n (0 = never).
    function automatic void model(input int n, output int n_eff, output bit to);
`ifdef RUN_WATCHDOG_EN
        to    = (n == 0) || (n > WDOG);
        n_eff = to ? WDOG : n;
`else
        to    = 1'b0;
        n_eff = n;
`endif
    endfunction

    task automatic do_run(input int h, input int n, input bit noise);
        int          n_eff;
        bit          to_exp;
        int          pi;
        int          pe;
        int          we;
        int          ack_at;
        logic [31:0] cnt_at;
        logic [31:0] to_at;
        int          cnt_exp;
        pi = 0; pe = 0; we = 0; ack_at = -1; cnt_at = '0; to_at = '0;
        model(n, n_eff, to_exp);
        cnt_exp = (n_eff > CNT_MAX) ? CNT_MAX : n_eff;
        for (int i = 0; i < h + n_eff + DRAIN + 20; i++) begin
            logic s;
            logic hl;
            s  = (i < h) || (noise && i > h && i <= h + n_eff && $urandom_range(0, 2) == 0);
            hl = (n != 0 && i == h + n) || (noise && i <= h && $urandom_range(0, 1) == 1);
            step(s, hl);
            if (i == 0) begin
                chk("arm_pcinit", PcInit, 1);
                chk("arm_ack_low", Ack, 0);
                chk("arm_cnt_clr", CycleCnt, 0);
                chk("arm_timeout_clr", Timeout, 0);
            end
            pi += int'(PcInit);
            pe += int'(PcEn);
            we += int'(WrEn);
            if (Ack) begin
                ack_at = i;
                cnt_at = 32'(CycleCnt);
                to_at  = 32'(Timeout);
                break;
            end
        end
        chk("ack_cycle", ack_at, h + n_eff + DRAIN);
        chk("pcinit_cycles", pi, h);
        chk("pcen_cycles", pe, n_eff);
        chk("wren_cycles", we, n_eff + DRAIN);
        chk("cycle_cnt", cnt_at, cnt_exp);
        chk("timeout", to_at, 32'(to_exp));
        // DONE holds Ack and the count while Start stays low.
        step(1'b0, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0);
        chk("done_ack_hold", Ack, 1);
        chk("done_cnt_hold", CycleCnt, cnt_exp);
        chk("done_pcen_low", PcEn, 0);
        $display("run h=%0d n=%0d n_eff=%0d cnt=%0d exp_cnt=%0d timeout=%0d ack_at=%0d",
                 h, n, n_eff, cnt_at, cnt_exp, to_at, ack_at);
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        Start = 1'b0;
        Halt  = 1'b0;

        // Reset held two cycles.
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("rst_pcinit", PcInit, 0);
        chk("rst_pcen", PcEn, 0);
        chk("rst_wren", WrEn, 0);
        chk("rst_ack", Ack, 0);
        chk("rst_cnt", CycleCnt, 0);
        chk("rst_timeout", Timeout, 0);
        chk("start_addr", 32'(StartAddr), START_ADDR);
        Reset = 1'b0;

        // Halt while idle is ignored.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("idle_halt_pcen", PcEn, 0);
        chk("idle_halt_ack", Ack, 0);

        // Directed runs: basic, restart from DONE, saturation.
        do_run(3, 5, 1'b0);
        do_run(2, 12, 1'b1);
        do_run(1, 20, 1'b0);

        // Reset in the middle of a run.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("midrun_pcen", PcEn, 1);
        chk("midrun_cnt", CycleCnt, 2);
        Reset = 1'b1;
        step(1'b0, 1'b0);
        Reset = 1'b0;
        chk("midrst_pcen", PcEn, 0);
        chk("midrst_wren", WrEn, 0);
        chk("midrst_cnt", CycleCnt, 0);
        chk("midrst_ack", Ack, 0);
        chk("midrst_pcinit", PcInit, 0);
        step(1'b0, 1'b1);
        chk("midrst_idle", PcEn, 0);

        // Randomized runs with Start noise in RUN and Halt noise outside RUN.
        for (int r = 0; r < 25; r++) begin
`ifdef RUN_WATCHDOG_EN
            n = $urandom_range(0, 20);
`else
            n = $urandom_range(1, 24);
`endif
            do_run($urandom_range(1, 4), n, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
